// File: rtl/md_frame_parser_pkg.sv
// Shared types and constants for the market-data frame parser.
// States, error codes and the message record used by parser and FIFO.
package md_pkg;

  typedef enum logic [2:0] {
    IDLE, HDR, SYM, PRC, QTY, CSUM, EOF, DROP
  } parse_state_e;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    BAD_TYPE = 3'd1,
    BAD_LEN  = 3'd2,
    BAD_CSUM = 3'd3,
    NO_TERM  = 3'd4,
    ABORT    = 3'd5,
    BAD_CTRL = 3'd6
  } err_code_e;

  typedef struct packed {
    logic [31:0] symbol;
    logic [31:0] price;
    logic [31:0] quantity;
  } md_msg_t;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

endpackage

// File: rtl/md_frame_parser_if.sv
// XGMII receive input plus valid/ready message output of the frame parser.
// The parser drives through 'master'; the consumer/source side uses 'slave'.
interface md_frame_parser_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] xgmii_rxd;
  logic [7:0]            xgmii_rxc;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_symbol;
  logic [31:0]           out_price;
  logic [31:0]           out_quantity;

  modport master (
    input  xgmii_rxd, xgmii_rxc, out_ready,
    output out_valid, out_symbol, out_price, out_quantity
  );

  modport slave (
    output xgmii_rxd, xgmii_rxc, out_ready,
    input  out_valid, out_symbol, out_price, out_quantity
  );
endinterface

// File: rtl/md_frame_parser_fifo.sv
// First-word-fall-through message FIFO; head reads as zero while empty.
// A pop in the same cycle frees the slot a push into a full FIFO needs.
module md_msg_fifo
  import md_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = md_msg_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/md_frame_parser.sv
// XGMII receive framing stage: delineates market-data frames, validates
// header and checksum, and queues {symbol, price, quantity} for the consumer.
module md_frame_parser
  import md_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  MSG_TYPE   = 8'h01,
  parameter logic [15:0] MSG_LEN    = 16'h0020
) (
  input  logic              clk,
  input  logic              rst,
  md_frame_parser_if.master bus,
  output logic              err_pulse,
  output logic [2:0]        err_code,
  output logic [31:0]       frames_ok,
  output logic [31:0]       frames_err,
  output logic [15:0]       overflow_cnt
);

  logic [31:0]  rxd_lo;
  logic [7:0]   rxc;
  logic         is_data, is_start, is_term;
  logic         unused_hi;

  parse_state_e state_q, state_d;
  err_code_e    err_d, err_code_q;
  logic         err_pulse_q, err_pulse_d;
  logic [31:0]  sym_q, sym_d, prc_q, prc_d, qty_q, qty_d;
  logic [31:0]  frames_ok_q, frames_ok_d, frames_err_q, frames_err_d;
  logic [15:0]  overflow_q, overflow_d;
  logic         commit, can_push, push, pop, fifo_full, fifo_empty;
  md_msg_t      commit_msg, head;

  assign rxd_lo    = bus.xgmii_rxd[31:0];
  assign rxc       = bus.xgmii_rxc;
  assign unused_hi = ^bus.xgmii_rxd[DATA_WIDTH-1:32];
  assign is_data   = (rxc == 8'h00);
  assign is_start  = (rxc == 8'h01) && (rxd_lo[7:0] == XGMII_START);
  assign is_term   = (rxc == 8'h01) && (rxd_lo[7:0] == XGMII_TERM);

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    prc_d   = prc_q;
    qty_d   = qty_q;
    err_d   = NONE;
    commit  = 1'b0;
    if ((state_q inside {HDR, SYM, PRC, QTY, CSUM}) && !is_data) begin
      // A fresh start mid-frame abandons the old frame but keeps the new one.
      if (is_start) begin
        err_d   = ABORT;
        state_d = HDR;
      end else begin
        err_d   = BAD_CTRL;
        state_d = is_term ? IDLE : DROP;
      end
    end else begin
      case (state_q)
        IDLE: if (is_start) state_d = HDR;
        HDR: begin
          if (rxd_lo[23:16] != MSG_TYPE) begin
            err_d   = BAD_TYPE;
            state_d = DROP;
          end else if (rxd_lo[15:0] != MSG_LEN) begin
            err_d   = BAD_LEN;
            state_d = DROP;
          end else begin
            state_d = SYM;
          end
        end
        SYM: begin sym_d = rxd_lo; state_d = PRC;  end
        PRC: begin prc_d = rxd_lo; state_d = QTY;  end
        QTY: begin qty_d = rxd_lo; state_d = CSUM; end
        CSUM: begin
          if (rxd_lo == (sym_q ^ prc_q ^ qty_q)) begin
            state_d = EOF;
          end else begin
            err_d   = BAD_CSUM;
            state_d = DROP;
          end
        end
        EOF: begin
          if (is_term) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = NO_TERM;
            state_d = DROP;
          end
        end
        DROP: begin
          if (is_term)       state_d = IDLE;
          else if (is_start) state_d = HDR;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop      = !fifo_empty && bus.out_ready;
  assign can_push = !fifo_full || pop;
  assign push     = commit && can_push;

  always_comb begin
    err_pulse_d  = (err_d != NONE);
    frames_err_d = frames_err_q + (err_pulse_d ? 32'd1 : 32'd0);
    frames_ok_d  = frames_ok_q + (push ? 32'd1 : 32'd0);
    overflow_d   = overflow_q + ((commit && !can_push) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      err_pulse_q  <= 1'b0;
      err_code_q   <= NONE;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_d;
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
      overflow_q   <= overflow_d;
    end
  end

  // Field registers are only consumed after being written in the same frame.
  always_ff @(posedge clk) begin
    sym_q <= sym_d;
    prc_q <= prc_d;
    qty_q <= qty_d;
  end

  assign commit_msg = '{symbol: sym_q, price: prc_q, quantity: qty_q};

  md_msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (md_msg_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (commit_msg),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid    = !fifo_empty;
  assign bus.out_symbol   = head.symbol;
  assign bus.out_price    = head.price;
  assign bus.out_quantity = head.quantity;
  assign err_pulse        = err_pulse_q;
  assign err_code         = err_code_q;
  assign frames_ok        = frames_ok_q;
  assign frames_err       = frames_err_q;
  assign overflow_cnt     = overflow_q;

endmodule

// File: tb/tb_md_frame_parser.sv
// Randomized bench for md_frame_parser against a frame-level reference model
// (expected outcome per injected fault kind, output queue of depth 4).
module tb_md_frame_parser;
  import md_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [31:0] frames_ok, frames_err;
  logic [15:0] overflow_cnt;

  md_frame_parser_if #(.DATA_WIDTH(64)) bus ();

  md_frame_parser #(
    .DATA_WIDTH (64),
    .FIFO_DEPTH (DEPTH),
    .MSG_TYPE   (8'h01),
    .MSG_LEN    (16'h0020)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .err_pulse    (err_pulse),
    .err_code     (err_code),
    .frames_ok    (frames_ok),
    .frames_err   (frames_err),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  md_msg_t     mq[$];
  int unsigned m_ok, m_err;
  logic [15:0] m_ovf;
  logic        ready;
  bit          rand_ready;
  md_msg_t     cur;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs(input int e);
    check_eq("err_pulse", 32'(err_pulse), 32'(e != 0));
    if (e != 0) check_eq("err_code", 32'(err_code), 32'(e));
    check_eq("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_eq("out_symbol", bus.out_symbol, mq[0].symbol);
      check_eq("out_price", bus.out_price, mq[0].price);
      check_eq("out_quantity", bus.out_quantity, mq[0].quantity);
    end
    check_eq("frames_ok", frames_ok, m_ok);
    check_eq("frames_err", frames_err, m_err);
    check_eq("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
  endtask

  // Drive one word, advance one clock, update the model, check.
  task automatic send_word(input logic [63:0] d, input logic [7:0] c, input int exp_err, input bit exp_commit);
    if (rand_ready) ready = ($urandom_range(0, 9) < 7);
    bus.xgmii_rxd = d;
    bus.xgmii_rxc = c;
    bus.out_ready = ready;
    @(posedge clk);
    if (mq.size() > 0 && ready) void'(mq.pop_front());
    if (exp_commit) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(cur);
        m_ok++;
      end else begin
        m_ovf++;
      end
    end
    if (exp_err != 0) m_err++;
    #1;
    check_outputs(exp_err);
  endtask

  task automatic w_data(input logic [31:0] v, input int e);
    send_word({$urandom(), v}, 8'h00, e, 1'b0);
  endtask

  task automatic w_start(input int e);
    send_word({$urandom(), 24'($urandom()), XGMII_START}, 8'h01, e, 1'b0);
  endtask

  task automatic w_term(input int e, input bit cm);
    send_word({$urandom(), 24'($urandom()), XGMII_TERM}, 8'h01, e, cm);
  endtask

  task automatic w_idle();
    send_word(64'h0707_0707_0707_0707, 8'hFF, 0, 1'b0);
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] t, input logic [15:0] l);
    return {8'($urandom()), t, l};
  endfunction

  // Words outside a frame are ignored: idles, stray data, stray terms.
  task automatic send_gap(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0: w_idle();
        1: w_data($urandom(), 0);
        default: w_term(0, 1'b0);
      endcase
    end
  endtask

  // kind: 0 good, 1 bad csum, 2 bad type, 3 bad len, 4 no term,
  //       5 abort then good, 6 term mid-frame, 7 other ctrl mid-frame
  task automatic send_frame(input int kind, input logic [31:0] s, input logic [31:0] p, input logic [31:0] q);
    logic [31:0] cs;
    cur = '{symbol: s, price: p, quantity: q};
    cs  = s ^ p ^ q;
    w_start(0);
    case (kind)
      0: begin
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data(s, 0); w_data(p, 0); w_data(q, 0); w_data(cs, 0);
        w_term(0, 1'b1);
      end
      1: begin
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data(s, 0); w_data(p, 0); w_data(q, 0); w_data(cs ^ 32'd1, 3);
        w_term(0, 1'b0);
      end
      2, 3: begin
        if (kind == 2) w_data(hdr(8'h02, 16'h0020), 1);
        else           w_data(hdr(8'h01, 16'h0018), 2);
        w_data(s, 0); w_data(p, 0); w_data(q, 0); w_data(cs, 0);
        w_term(0, 1'b0);
      end
      4: begin
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data(s, 0); w_data(p, 0); w_data(q, 0); w_data(cs, 0);
        w_data($urandom(), 4);
        w_term(0, 1'b0);
      end
      5: begin
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data($urandom(), 0); w_data($urandom(), 0);
        w_start(5);
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data(s, 0); w_data(p, 0); w_data(q, 0); w_data(cs, 0);
        w_term(0, 1'b1);
      end
      6: begin
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data(s, 0);
        w_term(6, 1'b0);
      end
      default: begin
        w_data(hdr(8'h01, 16'h0020), 0);
        w_data(s, 0); w_data(p, 0);
        w_idle_err();
        w_data($urandom(), 0);
        w_term(0, 1'b0);
      end
    endcase
  endtask

  task automatic w_idle_err();
    send_word(64'h0707_0707_0707_0707, 8'hFF, 6, 1'b0);
  endtask

  initial begin
    int k;
    m_ok = 0; m_err = 0; m_ovf = '0;
    ready = 1'b1; rand_ready = 1'b0;
    bus.xgmii_rxd = 64'h0707_0707_0707_0707;
    bus.xgmii_rxc = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset state
    #2 rst = 1'b1;
    #1 check_outputs(0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);
    check_eq("rst_out_symbol", bus.out_symbol, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Good frame, then bad checksum followed by a good frame
    send_frame(0, 32'h4141504C, 32'h000186A0, 32'h000000C8);
    send_gap(2);
    send_frame(1, 32'h4141504C, 32'h000186A0, 32'h000000C8);
    send_frame(0, 32'h4141504C, 32'h000186A0, 32'h000000C8);
    send_gap(1);

    // Abort, header errors, mid-frame control characters
    send_frame(5, 32'h49424D20, 32'h00002710, 32'h00000005);
    send_frame(2, 32'h58585858, 32'd1, 32'd2);
    send_frame(3, 32'h59595959, 32'd3, 32'd4);
    send_frame(6, 32'h5A5A5A5A, 32'd5, 32'd6);
    send_frame(7, 32'h5B5B5B5B, 32'd7, 32'd8);
    send_frame(4, 32'h5C5C5C5C, 32'd9, 32'd10);
    send_gap(2);

    // Backpressure: five back-to-back frames into a 4-deep queue
    ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(0, 32'h4D534654, 32'h00019A28, 32'(100 + i));
    ready = 1'b1;
    repeat (6) w_idle();

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 11);
      if (k > 7) k = 0;
      send_frame(k, $urandom(), $urandom(), $urandom());
      send_gap($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (6) w_idle();

    // Asynchronous reset mid-frame with a message held in the queue
    ready = 1'b0;
    send_frame(0, 32'h484F4C44, 32'd11, 32'd12);
    w_start(0);
    w_data(hdr(8'h01, 16'h0020), 0);
    w_data(32'h50415254, 0);
    w_data(32'd13, 0);
    @(negedge clk);
    bus.xgmii_rxd = 64'h0707_0707_0707_0707;
    bus.xgmii_rxc = 8'hFF;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_out_symbol", bus.out_symbol, 32'd0);
    check_eq("arst_out_price", bus.out_price, 32'd0);
    check_eq("arst_out_quantity", bus.out_quantity, 32'd0);
    check_eq("arst_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("arst_err_code", 32'(err_code), 32'd0);
    check_eq("arst_frames_ok", frames_ok, 32'd0);
    check_eq("arst_frames_err", frames_err, 32'd0);
    check_eq("arst_overflow", 32'(overflow_cnt), 32'd0);
    mq.delete();
    m_ok = 0; m_err = 0; m_ovf = '0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    ready = 1'b1;
    send_frame(0, 32'h54455354, 32'h00010005, 32'h00000007);
    repeat (3) w_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_frame_parser.md
Name: md_frame_parser

Overview:
- Receive-side framing stage. Sits between the 10G XGMII receive path (64-bit data, 8-bit control) and market_data_processor.
- Delineates market-data frames, checks header and checksum, and extracts symbol/price/quantity.
- Queues good messages in a small FIFO with a valid/ready output. Drops and counts bad frames.

Parameters:
- DATA_WIDTH, 64, XGMII data width; only 64 is supported.
- FIFO_DEPTH, 4, output message FIFO entries; power of two, at least 2.
- MSG_TYPE, 8'h01, required header type byte.
- MSG_LEN, 16'h0020, required header length field.

Ports:
- clk  in  1  156.25 MHz XGMII clock
- rst  in  1  asynchronous, active-high reset
- xgmii_rxd  in  64  receive data
- xgmii_rxc  in  8  receive control; bit i set marks byte i as a control character
- out_valid  out  1  message available
- out_ready  in  1  consumer accepts the message
- out_symbol  out  32  symbol (ASCII, first character in [31:24])
- out_price  out  32  price, fixed-point ×100
- out_quantity  out  32  quantity
- err_pulse  out  1  one-cycle pulse per rejected frame
- err_code  out  3  reason, valid while err_pulse is high
- frames_ok  out  32  good frames committed to the FIFO
- frames_err  out  32  rejected frames
- overflow_cnt  out  16  good frames dropped because the FIFO was full

Behaviour:
- Word classes:
  - start word: rxc==8'h01 and rxd[7:0]==8'hFB.
  - term word: rxc==8'h01 and rxd[7:0]==8'hFD.
  - data word: rxc==8'h00.
  - Payload fields use rxd[31:0]. rxd[63:32] is ignored.
- FSM states: IDLE, HDR, SYM, PRC, QTY, CSUM, EOF, DROP. Each state consumes one word per clock.
- IDLE:
  - start word -> HDR.
  - all other words are ignored; no error.
- HDR:
  - data word with rxd[23:16]==MSG_TYPE and rxd[15:0]==MSG_LEN -> SYM.
  - type mismatch -> error BAD_TYPE (code 1).
  - length mismatch -> error BAD_LEN (code 2). If both mismatch, report BAD_TYPE.
- SYM, PRC, QTY: each latches rxd[31:0] into its field register, then advances to the next state.
- CSUM:
  - compare rxd[31:0] with sym^prc^qty.
  - match -> EOF.
  - mismatch -> error BAD_CSUM (code 3).
- EOF:
  - term word -> commit the message, then IDLE.
  - any other word -> error NO_TERM (code 4).
- Control character mid-frame: in any of HDR..CSUM, a word that is not a data word is an error.
  - start word -> error ABORT (code 5), then go directly to HDR (the new frame is accepted).
  - anything else (including term) -> error BAD_CTRL (code 6), then IDLE if it was a term word, else DROP.
- Error action (unless stated otherwise above):
  - err_pulse high for the cycle after the offending word, with err_code set.
  - frames_err increments.
  - next state is DROP.
- DROP:
  - term word -> IDLE.
  - start word -> HDR.
  - all other words are discarded silently (no further errors).
- Commit:
  - FIFO not full: push {symbol, price, quantity}; frames_ok increments.
  - FIFO full: message discarded; overflow_cnt increments; frames_ok unchanged; no err_pulse.
- Latency: with the FIFO empty, out_valid rises on the clock after the term word is sampled.
- Output FIFO:
  - first-word fall-through.
  - out_* fields hold stable while out_valid is high and out_ready is low.
  - pop when out_valid and out_ready are both high.
  - push and pop in the same cycle while full: the pop frees the slot, so the push succeeds.
- Counters wrap modulo 2^width. No saturation.
- Back-to-back frames: a start word immediately after a term word is accepted, i.e. zero-word gap.
- Reset (asynchronous, at any time, including mid-frame):
  - FSM returns to IDLE; FIFO is emptied.
  - out_valid=0; out_symbol, out_price, out_quantity = 0.
  - err_pulse=0; err_code=0.
  - all counters = 0.
  - a partial frame in progress at reset is not counted.

Decomposition:
- Package md_pkg holds:
  - parse_state_e (8 states).
  - err_code_e: NONE=0, BAD_TYPE=1, BAD_LEN=2, BAD_CSUM=3, NO_TERM=4, ABORT=5, BAD_CTRL=6.
  - md_msg_t struct {symbol, price, quantity}.
  - constants XGMII_START=8'hFB and XGMII_TERM=8'hFD.
- One sub-module: md_msg_fifo.
  - parameterised by depth and md_msg_t.
  - FWFT, with full/empty outputs.
  - asynchronous active-high reset.

Test Plan:
- Good frame: start, header 0x010020, "AAPL" (0x4141504C), price 0x000186A0, quantity 0x000000C8, checksum = XOR of the three, term -> out_valid the next cycle with those three fields; frames_ok=1; no err_pulse.
- Bad checksum: same frame with checksum ^ 1 -> err_pulse with code 3; frames_err=1; out_valid stays 0; a following good frame is delivered.
- Backpressure: out_ready=0, five valid "MSFT" frames with price 0x00019A28 -> 4 entries held, overflow_cnt=1, frames_ok=4. Then out_ready=1 -> 4 pops in order with stable data.
- Abort: start word injected after PRC -> err code 5, frames_err=1. The frame that follows completes normally and is delivered.
- Header errors: type 0x02 -> code 1; length 0x0018 -> code 2. Each drops until term; no output.
- Reset mid-frame (asserted during QTY, async, off-edge): all outputs 0 immediately. After release, a full "TEST" frame with price 0x00010005 is delivered; counters show only the post-reset frame.
